// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the 9-digit multiplexed BCD display scanner.
// Segment codes are active-low, bit0 = a through bit6 = g.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 9;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit lookup, codes 10..15 fall through to the dash pattern
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed scanner for a 9-digit common-anode display with a blanking
// gap at the start of each slot and optional leading-zero suppression.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16,
    parameter int LZB       = 1
)(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Load,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD4,
    input  logic [3:0] BCD5,
    input  logic [3:0] BCD6,
    input  logic [3:0] BCD7,
    input  logic [3:0] BCD8,
    output logic [6:0] Seg,
    output logic [8:0] An,
    output logic       Frame_done
);

    localparam int               CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [3:0]       IDX_MAX   = 4'(NUM_DIGITS - 1);
    localparam scan_state_t      RST_STATE = (BLANK_CYC == 0) ? ST_SHOW : ST_GAP;

    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_idx;
    scan_state_t           r_state;
    logic [3:0]            r_shadow [NUM_DIGITS];
    logic [6:0]            r_seg;
    logic [8:0]            r_an;
    logic                  r_frame;

    logic [3:0]            w_bcd [NUM_DIGITS];
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_gap_nxt;
    logic [NUM_DIGITS-1:0] w_lead_zero;
    logic                  w_zero_run;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg;
    logic [8:0]            w_an;

    // Gather digit inputs into an indexable array
    always_comb begin
        w_bcd[0] = BCD0;
        w_bcd[1] = BCD1;
        w_bcd[2] = BCD2;
        w_bcd[3] = BCD3;
        w_bcd[4] = BCD4;
        w_bcd[5] = BCD5;
        w_bcd[6] = BCD6;
        w_bcd[7] = BCD7;
        w_bcd[8] = BCD8;
    end

    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? {CW{1'b0}} : (r_cnt + {{(CW-1){1'b0}}, 1'b1});

    // The gap compare is elided entirely when there is no gap
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign w_gap_nxt = 1'b0;
        end else begin : g_gap
            localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYC);
            assign w_gap_nxt = (w_cnt_nxt < BLANK_W);
        end
    endgenerate

    // Digit i is a leading zero when it and every more significant digit are zero
    always_comb begin
        w_lead_zero    = '0;
        w_zero_run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run     = w_zero_run && (r_shadow[i] == 4'd0);
            w_lead_zero[i] = w_zero_run && (LZB != 0);
        end
    end

    assign w_digit = (r_idx <= IDX_MAX) ? r_shadow[r_idx] : 4'd0;

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Anode pattern for the current slot before it is registered
    always_comb begin
        w_an = 9'h1FF;
        if ((r_state == ST_SHOW) && (r_idx <= IDX_MAX) && !w_lead_zero[r_idx]) begin
            w_an[r_idx] = 1'b0;
        end else begin
            w_an = 9'h1FF;
        end
    end

    // Scan counters, gap/show state, shadow capture and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_cnt   <= '0;
            r_idx   <= 4'd0;
            r_state <= RST_STATE;
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= 4'd0;
            r_seg   <= SEG_OFF;
            r_an    <= 9'h1FF;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            if (r_cnt == CNT_MAX) begin
                r_idx <= (r_idx >= IDX_MAX) ? 4'd0 : (r_idx + 4'd1);
            end else begin
                r_idx <= r_idx;
            end
            r_state <= w_gap_nxt ? ST_GAP : ST_SHOW;
            if (Load) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= w_bcd[i];
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= r_shadow[i];
            end
            r_seg   <= w_seg;
            r_an    <= w_an;
            r_frame <= (r_idx == IDX_MAX) && (r_cnt == CNT_MAX);
        end
    end

    assign Seg        = r_seg;
    assign An         = r_an;
    assign Frame_done = r_frame;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench: three scanner configurations driven by shared inputs and
// compared each cycle against a position-based reference model.
module tb_bcd_display_scan;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam int P_CD [0:2] = '{8, 8, 3};
    localparam int P_BC [0:2] = '{2, 2, 0};
    localparam int P_LZ [0:2] = '{1, 0, 1};

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Load;
    logic [3:0] bcd [0:8];

    logic [6:0] seg0, seg1, seg2;
    logic [8:0] an0, an1, an2;
    logic       fd0, fd1, fd2;

    int         checks;
    int         errors;
    int         pos;
    int         cyc;
    int         last_fd;
    logic [3:0] m_sh [0:8];

    always #5 Clk = ~Clk;

    bcd_display_scan #(.CLK_DIV(8), .BLANK_CYC(2), .LZB(1)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load),
        .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]), .BCD4(bcd[4]),
        .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]), .BCD8(bcd[8]),
        .Seg(seg0), .An(an0), .Frame_done(fd0));

    bcd_display_scan #(.CLK_DIV(8), .BLANK_CYC(2), .LZB(0)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load),
        .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]), .BCD4(bcd[4]),
        .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]), .BCD8(bcd[8]),
        .Seg(seg1), .An(an1), .Frame_done(fd1));

    bcd_display_scan #(.CLK_DIV(3), .BLANK_CYC(0), .LZB(1)) u2 (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load),
        .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]), .BCD4(bcd[4]),
        .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]), .BCD8(bcd[8]),
        .Seg(seg2), .An(an2), .Frame_done(fd2));

    // Expected anode pattern for a display with the given parameters, p cycles into the scan
    function automatic logic [8:0] exp_an(input int cd, input int bc, input int lz, input int p);
        int slot;
        int off;
        bit all_zero;
        slot     = (p / cd) % 9;
        off      = p % cd;
        all_zero = 1'b1;
        for (int j = slot; j < 9; j++) if (m_sh[j] != 4'd0) all_zero = 1'b0;
        if (off < bc) return 9'h1FF;
        if (lz == 1 && slot > 0 && all_zero) return 9'h1FF;
        return ~(9'd1 << slot);
    endfunction

    task automatic chk(input string tag, input int k, input logic [8:0] obs, input logic [8:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s u%0d cyc %0d observed %h expected %h", tag, k, cyc, obs, expv);
        end
    endtask

    task automatic step(input bit rst_n, input bit ld);
        logic [8:0] e_an  [0:2];
        logic [6:0] e_seg [0:2];
        logic       e_fd  [0:2];
        logic [8:0] a_an;
        logic [6:0] a_seg;
        logic       a_fd;
        Reset_n = rst_n;
        Load    = ld;
        @(posedge Clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                e_an[k]  = 9'h1FF;
                e_seg[k] = 7'h7F;
                e_fd[k]  = 1'b0;
            end else begin
                e_an[k]  = exp_an(P_CD[k], P_BC[k], P_LZ[k], pos);
                e_seg[k] = SEG_TAB[m_sh[(pos / P_CD[k]) % 9]];
                e_fd[k]  = ((pos % P_CD[k]) == P_CD[k] - 1) && (((pos / P_CD[k]) % 9) == 8);
            end
        end
        if (!rst_n) begin
            pos = 0;
            for (int i = 0; i < 9; i++) m_sh[i] = 4'd0;
        end else begin
            pos++;
            if (ld) for (int i = 0; i < 9; i++) m_sh[i] = bcd[i];
        end
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            a_an  = (k == 0) ? an0  : (k == 1) ? an1  : an2;
            a_seg = (k == 0) ? seg0 : (k == 1) ? seg1 : seg2;
            a_fd  = (k == 0) ? fd0  : (k == 1) ? fd1  : fd2;
            chk("an", k, a_an, e_an[k]);
            chk("frame_done", k, {8'd0, a_fd}, {8'd0, e_fd[k]});
            if (!rst_n || e_an[k] != 9'h1FF) chk("seg", k, {2'd0, a_seg}, {2'd0, e_seg[k]});
        end
        if (!rst_n) begin
            last_fd = -1;
        end else if (fd0 === 1'b1) begin
            if (last_fd >= 0) chk("frame_period", 0, 9'(cyc - last_fd), 9'd72);
            last_fd = cyc;
        end
    endtask

    task automatic set_all(input logic [3:0] v);
        for (int i = 0; i < 9; i++) bcd[i] = v;
    endtask

    initial begin
        int n;
        int nz;
        checks  = 0;
        errors  = 0;
        pos     = 0;
        cyc     = 0;
        last_fd = -1;
        Reset_n = 1'b0;
        Load    = 1'b0;
        set_all(4'd0);
        for (int i = 0; i < 9; i++) m_sh[i] = 4'd0;

        repeat (3) step(1'b0, 1'b0);

        // Digits 9..1 from BCD0 up to BCD8
        for (int i = 0; i < 9; i++) bcd[i] = 4'(9 - i);
        step(1'b1, 1'b1);
        repeat (160) step(1'b1, 1'b0);

        // Reset mid-scan, then measure latency to the first active digit-0 anode
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) bcd[i] = 4'(9 - i);
        n = 0;
        do begin
            step(1'b1, (n == 0));
            n++;
        end while (an0 !== 9'h1FE && n < 20);
        chk("first_an_latency", 0, 9'(n), 9'd3);
        repeat (80) step(1'b1, 1'b0);

        // Leading-zero cases
        set_all(4'd0); bcd[1] = 4'd4; bcd[0] = 4'd2;
        step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b0);
        set_all(4'd0);
        step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b0);

        // Non-decimal code inside a significant digit
        set_all(4'd0); bcd[8] = 4'd1; bcd[3] = 4'hC;
        step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b0);

        // Load while digit 4 is on screen
        set_all(4'd0); bcd[8] = 4'd1; bcd[4] = 4'd5;
        step(1'b1, 1'b1);
        n = 0;
        while (!(((pos / 8) % 9) == 4 && (pos % 8) == 4) && n < 200) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("slot4_reached", 0, 9'(n < 200), 9'd1);
        bcd[4] = 4'd8;
        step(1'b1, 1'b1);
        repeat (150) step(1'b1, 1'b0);

        // Load coinciding with reset must leave shadows cleared
        set_all(4'd9);
        step(1'b0, 1'b1);
        repeat (80) step(1'b1, 1'b0);

        // Random digits with random loads and occasional resets
        for (int t = 0; t < 800; t++) begin
            nz = $urandom_range(0, 9);
            for (int i = 0; i < 9; i++) bcd[i] = (i < nz) ? 4'($urandom_range(0, 15)) : 4'd0;
            step(($urandom % 150) != 0, ($urandom % 6) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, Clk cycles per digit slot; legal range CLK_DIV >= 2.
REQ-002 Parameter BLANK_CYC, default 16, anode-off cycles at the start of each slot; legal range 0 <= BLANK_CYC < CLK_DIV.
REQ-003 Parameter LZB, default 1, leading-zero blanking enable (1 = on).
REQ-004 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Reset_n  input  1  synchronous, active-low reset.
REQ-006 Load  input  1  when high at a rising edge, BCD0..BCD8 SHALL be captured into shadow registers.
REQ-007 BCD0..BCD8  input  4 each  digit values from the binary-to-BCD stage; BCD0 is least significant.
REQ-008 Seg  output  7  active-low segments; bit0=a through bit6=g.
REQ-009 An  output  9  active-low digit enables; An[i] drives digit i.
REQ-010 Frame_done  output  1  one-cycle pulse marking the end of a full 9-digit scan.

Function
REQ-011 Slot counter SHALL count 0..CLK_DIV-1, with width $clog2(CLK_DIV); at terminal count it SHALL wrap to 0 and advance digit index 0..8, wrapping 8->0.
REQ-012 FSM states SHALL be GAP and SHOW: GAP while counter < BLANK_CYC, SHOW otherwise; with BLANK_CYC=0, GAP SHALL never be entered.
REQ-013 In GAP, An SHALL be 9'h1FF; in SHOW, An SHALL be all ones except An[idx]=0, unless digit idx is blanked.
REQ-014 Digit i (i>0) SHALL be blanked (An all ones) when LZB=1 and shadow digits i..8 are all zero; digit 0 SHALL never be blanked.
REQ-015 Seg SHALL decode the shadow digit at idx: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10.
REQ-016 Codes 10..15 SHALL produce a dash, Seg=7'h3F.
REQ-017 Seg and An SHALL be registered outputs with one-cycle latency from the counter/index state.
REQ-018 Frame_done SHALL be high for exactly one cycle, registered, in the cycle after the last counter value of digit 8's slot; the period SHALL be 9*CLK_DIV cycles.
REQ-019 Load SHALL NOT reset or stall the scan; a new value SHALL appear on Seg one cycle after capture if its digit is current.
REQ-020 Load held high SHALL capture every cycle; shadow values SHALL hold while Load is low.
REQ-021 Reset_n low SHALL take priority over Load.

Reset
REQ-022 While Reset_n=0 at a rising edge: counter=0, idx=0, state=GAP (SHOW if BLANK_CYC=0), shadow registers=0, Seg=7'h7F, An=9'h1FF, Frame_done=0.
REQ-023 Reset asserted mid-scan SHALL restore the REQ-022 values on the next edge; after release the first slot SHALL be digit 0 from counter 0.

Structure
REQ-024 Package bcd_disp_pkg SHALL hold NUM_DIGITS=9, the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the FSM state typedef.
REQ-025 Combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out) SHALL implement REQ-015/016; all sequential logic stays in bcd_display_scan.

Verification (CLK_DIV=8, BLANK_CYC=2, LZB=1 unless stated)
REQ-026 Reset_n low 3 cycles during an active scan -> next cycle An=1FF, Seg=7F, Frame_done=0; after release the first An=1FE appears at cycle 3 (2 GAP cycles + 1 latency).
REQ-027 Load BCD8..BCD0=1,2,3,4,5,6,7,8,9 -> slot 0 shows Seg=7'h10 with An=1FE for 6 cycles after a 2-cycle 1FF gap; slot 8 shows Seg=7'h79 with An=0FF; Frame_done pulses every 72 cycles.
REQ-028 Load BCD1=4, BCD0=2, others 0 -> only slots 0 and 1 drive An low; all-zero load -> only slot 0 active, Seg=7'h40; LZB=0 with all zero -> all 9 slots show 7'h40.
REQ-029 Load BCD8=1, BCD3=4'hC -> slot 3 Seg=7'h3F, slot 3 not blanked.
REQ-030 Load during slot 4 changing BCD4 5->8 -> Seg goes 7'h12->7'h00 one cycle after capture; idx and counter unperturbed; Frame_done spacing stays 72.
REQ-031 Load and Reset_n low on the same edge -> shadow registers remain 0.
